// File: rtl/if_sram_fetch.sv
// Instruction-fetch responder: one outstanding SRAM read, registered result
// handed to decode over valid/ready, with redirect (flush) discard of wrong-path fetches.
`timescale 1ns/1ps
module if_sram_fetch #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_adel
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(WAIT_CYCLES);

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg;
  logic        killed_reg;
  logic [31:0] inst_reg;
  logic [31:0] pc_reg;
  logic        adel_reg;

  logic fire;
  logic aligned;
  logic capture;

  assign fire    = req_valid & req_ready;
  assign aligned = (req_addr[1:0] == 2'b00);
  assign capture = (state_reg == ST_WAIT) && (cnt_reg == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // flush wins everywhere; in FULL a same-cycle decode handshake is ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (fire) state_next = aligned ? ST_WAIT : ST_FULL;
      end
      ST_WAIT: begin
        if (capture) state_next = (killed_reg | flush) ? ST_IDLE : ST_FULL;
      end
      ST_FULL: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (inst_ready) begin
          if (fire) state_next = aligned ? ST_WAIT : ST_FULL;
          else      state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    inst_sram_en   = 1'b0;
    inst_sram_addr = 32'd0;
    inst_valid     = (state_reg == ST_FULL);
    if (!rst && !flush) begin
      req_ready = (state_reg == ST_IDLE) || ((state_reg == ST_FULL) && inst_ready);
    end
    if (fire && aligned) begin
      inst_sram_en   = 1'b1;
      inst_sram_addr = {req_addr[31:2], 2'b00};
    end
  end

  // Fire never occurs in WAIT, so the issue and capture updates cannot collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= 2'd0;
      killed_reg <= 1'b0;
      inst_reg   <= 32'd0;
      pc_reg     <= 32'd0;
      adel_reg   <= 1'b0;
    end else begin
      if (fire) begin
        pc_reg <= req_addr;
        if (aligned) begin
          cnt_reg <= WAIT_INIT;
        end else begin
          inst_reg <= 32'd0;
          adel_reg <= 1'b1;
        end
      end
      if (state_reg == ST_WAIT) begin
        if (cnt_reg == 2'd0) begin
          inst_reg   <= inst_sram_rdata;
          adel_reg   <= 1'b0;
          killed_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_reg - 2'd1;
          if (flush) killed_reg <= 1'b1;
        end
      end
    end
  end

  assign inst      = inst_reg;
  assign inst_pc   = pc_reg;
  assign inst_adel = adel_reg;

endmodule

// File: tb/tb_if_sram_fetch.sv
// Bench for if_sram_fetch: two instances (WAIT_CYCLES 0 and 2) behind a latency-exact
// SRAM model; a scoreboard queue holds expected deliveries of the instance under test.
`timescale 1ns/1ps
module tb_if_sram_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid, req_ready, flush, sram_en, inst_valid, inst_ready, inst_adel;
  logic [31:0] req_addr [2];
  logic [31:0] sram_addr [2];
  logic [31:0] sram_rdata [2];
  logic [31:0] inst [2];
  logic [31:0] inst_pc [2];

  int checks   = 0;
  int failures = 0;
  int act      = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        adel;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hbfc00000: return 32'h24080001;
      32'hbfc00004: return 32'h24090002;
      default:      return {a[15:0], ~a[15:0]} ^ 32'h13579bdf;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int W = gi * 2;
      logic [3:0]  en_pipe = 4'd0;
      logic [31:0] addr_pipe [4];

      if_sram_fetch #(.WAIT_CYCLES(W)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid[gi]),
        .req_addr       (req_addr[gi]),
        .req_ready      (req_ready[gi]),
        .flush          (flush[gi]),
        .inst_sram_en   (sram_en[gi]),
        .inst_sram_addr (sram_addr[gi]),
        .inst_sram_rdata(sram_rdata[gi]),
        .inst_valid     (inst_valid[gi]),
        .inst_ready     (inst_ready[gi]),
        .inst           (inst[gi]),
        .inst_pc        (inst_pc[gi]),
        .inst_adel      (inst_adel[gi])
      );

      // Data is valid only in the single cycle W+1 after the enable pulse.
      always @(posedge clk) begin
        en_pipe      <= {en_pipe[2:0], sram_en[gi]};
        addr_pipe[0] <= sram_addr[gi];
        for (int k = 1; k < 4; k++) addr_pipe[k] <= addr_pipe[k-1];
      end
      assign sram_rdata[gi] = en_pipe[W] ? mem_word(addr_pipe[W]) : 32'hdeadbeef;
    end
  endgenerate

  // Sample on the falling edge and run the scoreboard for the active instance.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (flush[act]) begin
      sbq.delete();
    end else begin
      if (inst_valid[act] && inst_ready[act]) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected dut%0d: got pc=%h inst=%h, required no delivery",
                   act, inst_pc[act], inst[act]);
        end else begin
          e = sbq.pop_front();
          if (inst_pc[act] !== e.pc || inst[act] !== e.word || inst_adel[act] !== e.adel) begin
            failures++;
            $display("FAIL sb_deliver dut%0d: got pc=%h inst=%h adel=%b, required pc=%h inst=%h adel=%b",
                     act, inst_pc[act], inst[act], inst_adel[act], e.pc, e.word, e.adel);
          end else begin
            $display("dut%0d deliver pc=%h inst=%h adel=%b", act, e.pc, e.word, e.adel);
          end
        end
      end
      if (req_valid[act] && req_ready[act]) begin
        e.pc   = req_addr[act];
        e.adel = (req_addr[act][1:0] != 2'b00);
        e.word = e.adel ? 32'd0 : mem_word(req_addr[act]);
        sbq.push_back(e);
      end
    end
    checks++;
    if (inst_valid[1-act] !== 1'b0 || sram_en[1-act] !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet dut%0d: got valid=%b en=%b, required 0 0",
               1 - act, inst_valid[1-act], sram_en[1-act]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d pending, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    req_valid  = 2'b11;
    flush      = 2'b00;
    inst_ready = 2'b11;
    req_addr[0] = 32'hbfc00000;
    req_addr[1] = 32'hbfc00000;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({req_ready[d], sram_en[d], inst_valid[d], inst_adel[d], inst[d], inst_pc[d], sram_addr[d]} !== '0) begin
        failures++;
        $display("FAIL reset_state dut%0d: got rdy=%b en=%b val=%b adel=%b inst=%h pc=%h addr=%h, required all 0",
                 d, req_ready[d], sram_en[d], inst_valid[d], inst_adel[d], inst[d], inst_pc[d], sram_addr[d]);
      end
    end
    advance();
    advance();
    req_valid = 2'b00;
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_stream();
    logic [31:0] pcs [2];
    int idx = 0;
    logic fired, exp_en, exp_val;
    pcs[0] = 32'hbfc00000;
    pcs[1] = 32'hbfc00004;
    act = 0;
    inst_ready[0] = 1'b1;
    req_valid[0]  = 1'b1;
    req_addr[0]   = pcs[0];
    for (int c = 1; c <= 6; c++) begin
      sample();
      exp_en  = (c == 1 || c == 3);
      exp_val = (c == 3 || c == 5);
      checks++;
      if (sram_en[0] !== exp_en) begin
        failures++;
        $display("FAIL stream_en c%0d: got %b, required %b", c, sram_en[0], exp_en);
      end
      checks++;
      if (inst_valid[0] !== exp_val) begin
        failures++;
        $display("FAIL stream_valid c%0d: got %b, required %b", c, inst_valid[0], exp_val);
      end
      checks++;
      if (exp_en) begin
        if (sram_addr[0] !== pcs[idx]) begin
          failures++;
          $display("FAIL stream_addr c%0d: got %h, required %h", c, sram_addr[0], pcs[idx]);
        end
      end else if (sram_addr[0] !== 32'd0) begin
        failures++;
        $display("FAIL stream_addr_idle c%0d: got %h, required 0", c, sram_addr[0]);
      end
      fired = req_valid[0] & req_ready[0];
      advance();
      if (fired) begin
        idx++;
        if (idx < 2) req_addr[0] = pcs[idx];
        else         req_valid[0] = 1'b0;
      end
    end
    drain_check("stream");
  endtask

  task automatic test_backpressure();
    logic [31:0] a = 32'hbfc00040;
    int n = 0;
    logic fired, exp_en, exp_val, exp_rdy;
    act = 0;
    req_valid[0] = 1'b1;
    req_addr[0]  = a;
    for (int c = 1; c <= 10; c++) begin
      inst_ready[0] = !(c >= 3 && c <= 6);
      sample();
      exp_en  = (c == 1 || c == 7);
      exp_val = (c >= 3 && c <= 7) || (c == 9);
      exp_rdy = (c == 1 || c == 7 || c >= 9);
      checks++;
      if ({req_ready[0], sram_en[0], inst_valid[0]} !== {exp_rdy, exp_en, exp_val}) begin
        failures++;
        $display("FAIL bp_ctrl c%0d: got rdy/en/val=%b%b%b, required %b%b%b",
                 c, req_ready[0], sram_en[0], inst_valid[0], exp_rdy, exp_en, exp_val);
      end
      if (c >= 3 && c <= 7) begin
        checks++;
        if (inst[0] !== mem_word(a) || inst_pc[0] !== a) begin
          failures++;
          $display("FAIL bp_hold c%0d: got inst=%h pc=%h, required inst=%h pc=%h",
                   c, inst[0], inst_pc[0], mem_word(a), a);
        end
      end
      fired = req_valid[0] & req_ready[0];
      advance();
      if (fired) begin
        n++;
        if (n == 1) req_addr[0] = a + 32'd4;
        else        req_valid[0] = 1'b0;
      end
    end
    drain_check("bp");
  endtask

  task automatic test_flush_wait();
    int n = 0;
    logic fired, exp_en, exp_val, exp_rdy;
    act = 1;
    inst_ready[1] = 1'b1;
    req_valid[1]  = 1'b1;
    req_addr[1]   = 32'hbfc00010;
    for (int c = 1; c <= 10; c++) begin
      flush[1] = (c == 2);
      sample();
      exp_en  = (c == 1 || c == 5);
      exp_val = (c == 9);
      exp_rdy = (c == 1 || c == 5 || c >= 9);
      checks++;
      if ({req_ready[1], sram_en[1], inst_valid[1]} !== {exp_rdy, exp_en, exp_val}) begin
        failures++;
        $display("FAIL flush_wait c%0d: got rdy/en/val=%b%b%b, required %b%b%b",
                 c, req_ready[1], sram_en[1], inst_valid[1], exp_rdy, exp_en, exp_val);
      end
      if (c == 5) begin
        checks++;
        if (sram_addr[1] !== 32'hbfc00380) begin
          failures++;
          $display("FAIL flush_wait_addr: got %h, required bfc00380", sram_addr[1]);
        end
      end
      fired = req_valid[1] & req_ready[1];
      advance();
      if (fired) begin
        n++;
        if (n == 1) req_addr[1] = 32'hbfc00380;
        else        req_valid[1] = 1'b0;
      end
    end
    flush[1] = 1'b0;
    drain_check("flush_wait");
  endtask

  task automatic test_flush_capture();
    logic fired, exp_rdy;
    act = 1;
    inst_ready[1] = 1'b1;
    req_valid[1]  = 1'b1;
    req_addr[1]   = 32'hbfc00100;
    for (int c = 1; c <= 7; c++) begin
      flush[1] = (c == 4);
      sample();
      exp_rdy = (c == 1 || c >= 5);
      checks++;
      if ({req_ready[1], inst_valid[1]} !== {exp_rdy, 1'b0}) begin
        failures++;
        $display("FAIL flush_capture c%0d: got rdy/val=%b%b, required %b0",
                 c, req_ready[1], inst_valid[1], exp_rdy);
      end
      fired = req_valid[1] & req_ready[1];
      advance();
      if (fired) req_valid[1] = 1'b0;
    end
    flush[1] = 1'b0;
    drain_check("flush_capture");
  endtask

  task automatic test_flush_full();
    int n = 0;
    logic fired, exp_en, exp_val, exp_rdy;
    act = 0;
    inst_ready[0] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      req_valid[0] = (n == 0 && c == 1) || (n == 1 && c >= 3);
      req_addr[0]  = (n == 0) ? 32'hbfc00200 : 32'hbfc00204;
      flush[0]     = (c == 3);
      sample();
      exp_en  = (c == 1 || c == 4);
      exp_val = (c == 3 || c == 6);
      exp_rdy = (c == 1 || c == 4 || c >= 6);
      checks++;
      if ({req_ready[0], sram_en[0], inst_valid[0]} !== {exp_rdy, exp_en, exp_val}) begin
        failures++;
        $display("FAIL flush_full c%0d: got rdy/en/val=%b%b%b, required %b%b%b",
                 c, req_ready[0], sram_en[0], inst_valid[0], exp_rdy, exp_en, exp_val);
      end
      fired = req_valid[0] & req_ready[0];
      advance();
      if (fired) n++;
    end
    req_valid[0] = 1'b0;
    flush[0]     = 1'b0;
    drain_check("flush_full");
  endtask

  task automatic test_misaligned();
    logic fired;
    int n = 0;
    act = 0;
    inst_ready[0] = 1'b1;
    req_valid[0]  = 1'b1;
    req_addr[0]   = 32'hbfc00002;
    for (int c = 1; c <= 5; c++) begin
      sample();
      if (c == 1) begin
        checks++;
        if ({req_ready[0], sram_en[0]} !== 2'b10) begin
          failures++;
          $display("FAIL mis_issue: got rdy/en=%b%b, required 10", req_ready[0], sram_en[0]);
        end
      end
      if (c == 2) begin
        checks++;
        if (inst_valid[0] !== 1'b1 || inst_adel[0] !== 1'b1 || inst[0] !== 32'd0 || inst_pc[0] !== 32'hbfc00002) begin
          failures++;
          $display("FAIL mis_entry: got val=%b adel=%b inst=%h pc=%h, required 1 1 00000000 bfc00002",
                   inst_valid[0], inst_adel[0], inst[0], inst_pc[0]);
        end
        checks++;
        if (sram_en[0] !== 1'b1 || sram_addr[0] !== 32'hbfc00008) begin
          failures++;
          $display("FAIL mis_next_issue: got en=%b addr=%h, required 1 bfc00008", sram_en[0], sram_addr[0]);
        end
      end
      if (c == 4) begin
        checks++;
        if (inst_valid[0] !== 1'b1 || inst_adel[0] !== 1'b0) begin
          failures++;
          $display("FAIL mis_recover: got val=%b adel=%b, required 1 0", inst_valid[0], inst_adel[0]);
        end
      end
      fired = req_valid[0] & req_ready[0];
      advance();
      if (fired) begin
        n++;
        if (n == 1) req_addr[0] = 32'hbfc00008;
        else        req_valid[0] = 1'b0;
      end
    end
    drain_check("mis");
  endtask

  task automatic test_reset_mid_wait();
    act = 1;
    inst_ready[1] = 1'b1;
    req_valid[1]  = 1'b1;
    req_addr[1]   = 32'hbfc00020;
    sample();
    advance();
    req_valid[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready[1], sram_en[1], inst_valid[1], inst_adel[1], inst[1], inst_pc[1]} !== '0) begin
      failures++;
      $display("FAIL rst_async: got rdy=%b en=%b val=%b adel=%b inst=%h pc=%h, required all 0",
               req_ready[1], sram_en[1], inst_valid[1], inst_adel[1], inst[1], inst_pc[1]);
    end
    sbq.delete();
    advance();
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      sample();
      checks++;
      if (inst_valid[1] !== 1'b0 || inst[1] !== 32'd0) begin
        failures++;
        $display("FAIL rst_abort c%0d: got val=%b inst=%h, required 0 00000000", c, inst_valid[1], inst[1]);
      end
      advance();
    end
    drain_check("rst");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_wait();
    test_flush_capture();
    test_flush_full();
    test_misaligned();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_sram_fetch.md
# if_sram_fetch

Instruction-fetch responder between the PC register and the synchronous instruction SRAM. It accepts one fetch address per handshake, drives the SRAM read port, and waits the configured SRAM latency. It registers the returned word and presents it to decode with a valid/ready handshake. Its `req_ready` output is the PC's `pc_en`. Its `flush` input is driven by the same exception/branch redirect that steers the PC, so in-flight fetches of the wrong path are discarded.

## Interface
- `WAIT_CYCLES`, default 0: extra SRAM wait states, range 0..3. Read data is valid `WAIT_CYCLES+1` cycles after the enable pulse.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid` input 1: the PC presents a fetch address.
- `req_addr` input 32: fetch address (`pc_reg`).
- `req_ready` output 1: the request is accepted this cycle; drives `pc_en`.
- `flush` input 1: redirect; kill the current and in-flight fetch.
- `inst_sram_en` output 1: SRAM read enable; one-cycle pulse per access.
- `inst_sram_addr` output 32: word-aligned read address.
- `inst_sram_rdata` input 32: SRAM read data.
- `inst_valid` output 1: the instruction register holds a valid entry.
- `inst_ready` input 1: decode accepts the entry.
- `inst` output 32: fetched instruction word.
- `inst_pc` output 32: address of `inst`.
- `inst_adel` output 1: address-error flag; the fetch address was misaligned.

## Operation
- FSM states: IDLE, WAIT, FULL. One request outstanding at most.
- Issue condition is `fire = req_valid & req_ready`.
  - `req_ready` is 0 when `rst` or `flush` is high.
  - Otherwise it is 1 in IDLE, 0 in WAIT, and equals `inst_ready` in FULL.
- On `fire` with `req_addr[1:0]==0`:
  - Assert `inst_sram_en` and set `inst_sram_addr = {req_addr[31:2],2'b00}`, both combinational from `fire`.
  - Latch `inst_pc <= req_addr`.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT.
- On `fire` with `req_addr[1:0]!=0`:
  - No SRAM access; `inst_sram_en` stays 0.
  - Set `inst_pc <= req_addr`, `inst <= 0`, `inst_adel <= 1`.
  - Go to FULL.
- WAIT:
  - The 2-bit counter decrements each cycle.
  - When the counter reads 0, capture `inst <= inst_sram_rdata` and `inst_adel <= 0`.
  - If the `killed` flag is clear, go to FULL; if it is set, go to IDLE and clear `killed`.
- `flush` in WAIT sets `killed`. The SRAM data still arrives but is discarded, and `inst_valid` never asserts for it. A `flush` in the capture cycle itself also discards.
- FULL: `inst_valid=1`.
  - On `inst_ready & !flush`: go to WAIT if a new issue fires in the same cycle, otherwise go to IDLE.
  - With `inst_ready=0`, hold `inst`, `inst_pc` and `inst_adel` stable.
- `flush` in FULL forces IDLE next cycle. A decode handshake in the same cycle is treated as not having occurred; decode is flushed too.
- `flush` has priority over every other event in every state.

## Timing
- Reset values:
  - state IDLE; `inst_valid=0`, `inst=0`, `inst_pc=0`, `inst_adel=0`.
  - counter 0, `killed` 0.
  - `req_ready=0` and `inst_sram_en=0` while `rst` is high.
- Latency: issue in cycle t; data is captured at the end of cycle `t+1+WAIT_CYCLES`; `inst_valid` is high from cycle `t+2+WAIT_CYCLES`.
- Throughput: one instruction per `WAIT_CYCLES+2` cycles when decode is always ready, because the issue overlaps the FULL cycle.
- A misaligned fetch has 1-cycle latency (`inst_valid` in t+1).
- `inst_sram_addr` is 0 when `inst_sram_en=0`.
- Reset asserted mid-access returns the block to IDLE immediately. A later SRAM response is ignored.

## Test plan
- Aligned streaming, `WAIT_CYCLES=0`, `inst_ready=1`:
  - PC issues 0xbfc00000, 0xbfc00004; SRAM returns 0x24080001, 0x24090002.
  - Required: `inst_sram_en` pulses in cycles 1 and 3; `inst_valid` is high in cycles 3 and 5 with matching `inst` and `inst_pc`.
- Backpressure: `inst_ready=0` for 4 cycles in FULL.
  - Required: `req_ready=0`, no `inst_sram_en`, and `inst`/`inst_pc` stable; the next issue occurs in the cycle `inst_ready` rises.
- Flush in WAIT with `WAIT_CYCLES=2`:
  - Stimulus: `flush` 1 cycle after issuing 0xbfc00010.
  - Required: 0xbfc00010 never appears with `inst_valid=1`; the next request (0xbfc00380) is accepted only after the in-flight slot returns to IDLE.
- Misaligned fetch: `req_addr=0xbfc00002`.
  - Required: no `inst_sram_en`; the next cycle shows `inst_valid=1`, `inst_adel=1`, `inst=0`, `inst_pc=0xbfc00002`.
- Async reset mid-WAIT:
  - Stimulus: `rst` pulsed between clock edges.
  - Required: all outputs return to reset values immediately; no `inst_valid` appears from the aborted access.
